traffic_controller_nphase: RTL and testbench
============================================

Name: traffic_controller_nphase

Overview:
Parametrised successor to the two-direction fixed-time traffic controller. It sequences NUM_PHASES signal phases (SAFE -> GREEN -> YELLOW -> ALL_RED -> next phase) using latched vehicle demand, detector-based green extension, rest-in-green, and demand-based phase skipping. It keeps the illegal-state recovery to SAFE and adds a fault pulse. It sits directly behind the intersection I/O and drives one green/yellow/red lamp triple per phase.

Parameters:
NUM_PHASES, 2, number of phases (2..8)
TW, 8, timer width in bits; every time parameter must be 1..2^TW-1
GREEN_MIN, 10, minimum green in clk cycles
GREEN_MAX, 60, maximum green before yielding to competing demand
GAP_TIME, 3, extension gap: green may end only after det[cur] has been low this many cycles
YELLOW_TIME, 4, yellow duration
ALLRED_TIME, 3, all-red clearance duration
SAFE_TIME_RESET, 15, SAFE duration after reset release
SAFE_TIME, 4, SAFE duration after a fault

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
req  in  NUM_PHASES  vehicle/pedestrian call per phase, level or pulse
det  in  NUM_PHASES  presence detector per phase, used for extension
green  out  NUM_PHASES  green lamp per phase
yellow  out  NUM_PHASES  yellow lamp per phase
red  out  NUM_PHASES  red lamp per phase
cur_phase  out  3  phase currently served (last served while in SAFE/ALL_RED)
fault  out  1  one-cycle pulse on illegal-state detection

Behaviour:
- Clock and reset are fixed: one clock, clk; reset resetn is asynchronous and active-low. All flops are clocked by clk only.
- Reset state: SAFE; timer = SAFE_TIME_RESET-1; cur_phase = NUM_PHASES-1; demand = 0.
- Output reset values: red all 1, green 0, yellow 0, fault 0.
- Outputs decode from registered state only. There is no combinational path from req/det to the lamps.
- Lamp invariants, every cycle:
  - For each phase i, exactly one of green[i], yellow[i], red[i] is 1.
  - At most one phase is non-red.
- Timed states (SAFE, YELLOW, ALL_RED) load the timer with T-1 on entry and last exactly T cycles. The last cycle is the one where timer==0.
- Demand latch:
  - demand[i] is set by req[i].
  - demand[i] is cleared on the cycle phase i enters GREEN. A req[i] on that same cycle is absorbed (served).
  - req for the currently green phase is ignored.
- Next-phase select (end of SAFE or ALL_RED):
  - Take the first i with demand[i], searching cyclically from cur_phase+1.
  - If no demand, take (cur_phase+1) mod NUM_PHASES.
  - Undemanded phases in between are skipped (no yellow/all-red for them).
- GREEN uses cycle counter k=1,2,... (saturating at GREEN_MAX) and a gap counter.
  - The gap counter reloads GAP_TIME on every cycle det[cur_phase]=1. It expires after GAP_TIME consecutive det-low cycles.
  - Exit to YELLOW after cycle k when all three hold: (a) k>=GREEN_MIN; (b) gap expired OR k>=GREEN_MAX; (c) any demand[j] with j!=cur_phase.
  - If (c) is false, rest in green indefinitely. When demand arrives, exit on the cycle after it latches, provided (a) and (b) hold.
- YELLOW then ALL_RED for the current phase, then next-phase select.
- Fault recovery:
  - A fault is an unused state encoding or cur_phase>=NUM_PHASES.
  - Next cycle: enter SAFE, load timer SAFE_TIME-1, fault=1 for one cycle, all red.
  - Demand latches are preserved.
- Reset mid-operation: all lamps go red immediately (asynchronously) and the reset sequence restarts.

Optional Feature:
MAINT_FLASH_EN
- Defined:
  - Adds input flash_req (1 bit) and parameter FLASH_HALF (default 8).
  - flash_req=1 in GREEN forces exit to YELLOW once k>=GREEN_MIN. Extension and demand are ignored. YELLOW and ALL_RED then run normally.
  - flash_req=1 in SAFE/ALL_RED enters FLASH at that state's end.
  - FLASH: all red toggle together every FLASH_HALF cycles, starting lit; green and yellow stay 0.
  - Exit FLASH at the first half-period boundary with flash_req=0, into SAFE with SAFE_TIME.
- Undefined: no flash_req port exists, and the FLASH encoding counts as illegal (fault recovery).

Test Plan:
1. Bench parameters for every scenario except 6: NUM_PHASES=3, GREEN_MIN=4, GREEN_MAX=10, GAP_TIME=2, YELLOW_TIME=3, ALLRED_TIME=2, SAFE_TIME_RESET=5, SAFE_TIME=4.
2. Reset release with req=0 -> red=3'b111 for exactly 5 cycles, then green=3'b001 held (rest); cur_phase=0.
3. Phase 0 green, det=0, req[1] pulse at green cycle 1 -> green[0] exactly 4 cycles, yellow[0] 3, all red 2, then green[1]=1, cur_phase=1.
4. det[0] held high, req[2] pending -> green[0] exactly 10 cycles (max), then yellow[0]. Repeat with det[0] dropped after cycle 5 -> green lasts 7 cycles.
5. From green[0], only req[2] pending -> after all-red, green[2]=1; green[1] never asserts; demand[2] clears.
6. Fault: force state to an unused encoding in GREEN -> next cycle fault=1 for one cycle, red all 1 for 4 cycles, then normal selection with pre-fault demand kept. With MAINT_FLASH_EN, flash_req=1 -> red toggles with an 8-cycle half period; release -> SAFE 4 cycles.

Source files
------------

// File: rtl/traffic_controller_nphase.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : traffic_controller_nphase
// Description : N-phase actuated traffic controller. It sequences
//               SAFE -> GREEN -> YELLOW -> ALL_RED -> next phase. Features:
//               latched demand, detector gap extension, rest-in-green,
//               demand-based phase skipping, and illegal-state recovery
//               to SAFE with a one-cycle fault pulse.
//               Optional feature macro: MAINT_FLASH_EN (adds flash_req,
//               FLASH_HALF and the all-red flashing maintenance state).
// Revision    : 1.0 - initial release
//==============================================================================
module traffic_controller_nphase #(
   parameter int NUM_PHASES      = 2,
   parameter int TW              = 8,
   parameter int GREEN_MIN       = 10,
   parameter int GREEN_MAX       = 60,
   parameter int GAP_TIME        = 3,
   parameter int YELLOW_TIME     = 4,
   parameter int ALLRED_TIME     = 3,
   parameter int SAFE_TIME_RESET = 15,
   parameter int SAFE_TIME       = 4
`ifdef MAINT_FLASH_EN
   ,parameter int FLASH_HALF     = 8
`endif
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [NUM_PHASES-1:0] req,
   input  logic [NUM_PHASES-1:0] det,
`ifdef MAINT_FLASH_EN
   input  logic                  flash_req,
`endif
   output logic [NUM_PHASES-1:0] green,
   output logic [NUM_PHASES-1:0] yellow,
   output logic [NUM_PHASES-1:0] red,
   output logic [2:0]            cur_phase,
   output logic                  fault
);

   // Encodings 5..7 are never produced; FLASH is illegal when the
   // maintenance feature is not built in.
   typedef enum logic [2:0] {
      ST_SAFE   = 3'd0,
      ST_GREEN  = 3'd1,
      ST_YELLOW = 3'd2,
      ST_ALLRED = 3'd3,
      ST_FLASH  = 3'd4
   } state_t;

   localparam logic [TW-1:0] c_safe_rst_ld = TW'(SAFE_TIME_RESET - 1);
   localparam logic [TW-1:0] c_safe_ld     = TW'(SAFE_TIME - 1);
   localparam logic [TW-1:0] c_yellow_ld   = TW'(YELLOW_TIME - 1);
   localparam logic [TW-1:0] c_allred_ld   = TW'(ALLRED_TIME - 1);
   localparam logic [TW-1:0] c_gap_ld      = TW'(GAP_TIME);
   localparam logic [TW-1:0] c_green_min   = TW'(GREEN_MIN);
   localparam logic [TW-1:0] c_green_max   = TW'(GREEN_MAX);
   localparam logic [TW-1:0] c_one         = TW'(1);
   localparam logic [2:0]    c_last_phase  = 3'(NUM_PHASES - 1);
   localparam logic [3:0]    c_num_phases  = 4'(NUM_PHASES);
`ifdef MAINT_FLASH_EN
   localparam logic [TW-1:0] c_flash_ld    = TW'(FLASH_HALF - 1);
`endif

   // Raw 3-bit state so that unused encodings are representable and caught.
   logic [2:0]            r_state;
   logic [2:0]            w_state_nxt;
   logic [TW-1:0]         r_timer;
   logic [TW-1:0]         w_timer_nxt;
   logic [2:0]            r_cur;
   logic [2:0]            w_cur_nxt;
   logic [NUM_PHASES-1:0] r_demand;
   logic [NUM_PHASES-1:0] w_demand_nxt;
   logic [TW-1:0]         r_k;
   logic [TW-1:0]         w_k_nxt;
   logic [TW-1:0]         r_gap;
   logic [TW-1:0]         w_gap_nxt;
   logic                  r_fault;
   logic                  w_fault_nxt;
   logic                  r_flash_on;
   logic                  w_flash_nxt;

   logic                  w_cur_ok;
   logic                  w_state_ok;
   logic                  w_illegal;
   logic                  w_timer_zero;
   logic [NUM_PHASES-1:0] w_cur_oh;
   logic [NUM_PHASES-1:0] w_sel_oh;
   logic                  w_det_cur;
   logic                  w_other_dem;
   logic [2:0]            w_succ;
   logic [2:0]            w_sel_phase;
   int                    w_dist;
   int                    w_best;
   logic [TW-1:0]         w_gap_now;
   logic                  w_green_done;
   logic                  w_enter_green;
   logic                  w_flash_go;

   // Legality of the registered state and phase pointer.
   always_comb begin
      w_cur_ok     = ({1'b0, r_cur} < c_num_phases);
      w_timer_zero = (r_timer == '0);
      case (r_state)
         ST_SAFE, ST_GREEN, ST_YELLOW, ST_ALLRED: w_state_ok = 1'b1;
`ifdef MAINT_FLASH_EN
         ST_FLASH:                               w_state_ok = 1'b1;
`endif
         default:                                w_state_ok = 1'b0;
      endcase
      w_illegal = !w_state_ok || !w_cur_ok;
   end

   // Per-phase views of the current phase: one-hot, its detector, rival demand.
   always_comb begin
      w_cur_oh    = '0;
      w_det_cur   = 1'b0;
      w_other_dem = 1'b0;
      for (int j = 0; j < NUM_PHASES; j++) begin
         if (3'(j) == r_cur) begin
            w_cur_oh[j] = 1'b1;
            w_det_cur   = det[j];
         end else if (r_demand[j]) begin
            w_other_dem = 1'b1;
         end
      end
   end

   // Cyclic search for the nearest demanded phase after the current one.
   always_comb begin
      w_succ      = (r_cur >= c_last_phase) ? 3'd0 : r_cur + 3'd1;
      w_sel_phase = w_succ;
      w_best      = NUM_PHASES;
      w_dist      = 0;
      w_sel_oh    = '0;
      for (int j = 0; j < NUM_PHASES; j++) begin
         w_dist = j - int'(w_succ);
         if (w_dist < 0) begin
            w_dist = w_dist + NUM_PHASES;
         end
         if (r_demand[j] && (w_dist < w_best)) begin
            w_best      = w_dist;
            w_sel_phase = 3'(j);
         end
      end
      for (int j = 0; j < NUM_PHASES; j++) begin
         w_sel_oh[j] = (3'(j) == w_sel_phase);
      end
   end

   // Green termination: minimum served, gap out or max reached, rival waiting.
   always_comb begin
      w_gap_now    = w_det_cur ? c_gap_ld : ((r_gap == '0) ? '0 : r_gap - c_one);
      w_green_done = (r_k >= c_green_min) &&
                     ((w_gap_now == '0) || (r_k >= c_green_max)) && w_other_dem;
`ifdef MAINT_FLASH_EN
      w_flash_go   = flash_req;
      if (flash_req && (r_k >= c_green_min)) begin
         w_green_done = 1'b1;
      end
`else
      w_flash_go   = 1'b0;
`endif
   end

   // Next-state and datapath load decisions.
   always_comb begin
      w_state_nxt   = r_state;
      w_timer_nxt   = r_timer;
      w_cur_nxt     = r_cur;
      w_k_nxt       = r_k;
      w_gap_nxt     = r_gap;
      w_fault_nxt   = 1'b0;
      w_flash_nxt   = r_flash_on;
      w_enter_green = 1'b0;
      if (w_illegal) begin
         w_state_nxt = ST_SAFE;
         w_timer_nxt = c_safe_ld;
         w_fault_nxt = 1'b1;
         if (!w_cur_ok) begin
            w_cur_nxt = c_last_phase;
         end
      end else begin
         case (r_state)
            ST_SAFE, ST_ALLRED: begin
               if (!w_timer_zero) begin
                  w_timer_nxt = r_timer - c_one;
               end else if (w_flash_go) begin
                  w_state_nxt = ST_FLASH;
`ifdef MAINT_FLASH_EN
                  w_timer_nxt = c_flash_ld;
`endif
                  w_flash_nxt = 1'b1;
               end else begin
                  w_state_nxt   = ST_GREEN;
                  w_cur_nxt     = w_sel_phase;
                  w_k_nxt       = c_one;
                  w_gap_nxt     = c_gap_ld;
                  w_enter_green = 1'b1;
               end
            end
            ST_GREEN: begin
               w_gap_nxt = w_gap_now;
               w_k_nxt   = (r_k >= c_green_max) ? r_k : r_k + c_one;
               if (w_green_done) begin
                  w_state_nxt = ST_YELLOW;
                  w_timer_nxt = c_yellow_ld;
               end
            end
            ST_YELLOW: begin
               if (w_timer_zero) begin
                  w_state_nxt = ST_ALLRED;
                  w_timer_nxt = c_allred_ld;
               end else begin
                  w_timer_nxt = r_timer - c_one;
               end
            end
`ifdef MAINT_FLASH_EN
            ST_FLASH: begin
               if (!w_timer_zero) begin
                  w_timer_nxt = r_timer - c_one;
               end else if (flash_req) begin
                  w_timer_nxt = c_flash_ld;
                  w_flash_nxt = !r_flash_on;
               end else begin
                  w_state_nxt = ST_SAFE;
                  w_timer_nxt = c_safe_ld;
                  w_flash_nxt = 1'b0;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // Demand latch: set by req, masked for the green phase, cleared on service.
   always_comb begin
      w_demand_nxt = r_demand | req;
      if (!w_illegal && (r_state == ST_GREEN)) begin
         w_demand_nxt = w_demand_nxt & ~w_cur_oh;
      end
      if (w_enter_green) begin
         w_demand_nxt = w_demand_nxt & ~w_sel_oh;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= ST_SAFE;
         r_timer    <= c_safe_rst_ld;
         r_cur      <= c_last_phase;
         r_demand   <= '0;
         r_k        <= '0;
         r_gap      <= '0;
         r_fault    <= 1'b0;
         r_flash_on <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_timer    <= w_timer_nxt;
         r_cur      <= w_cur_nxt;
         r_demand   <= w_demand_nxt;
         r_k        <= w_k_nxt;
         r_gap      <= w_gap_nxt;
         r_fault    <= w_fault_nxt;
         r_flash_on <= w_flash_nxt;
      end
   end

   // Lamp decode from registered state only; anything unexpected shows all red.
   always_comb begin
      green  = '0;
      yellow = '0;
      red    = '1;
      case (r_state)
         ST_GREEN: begin
            green = w_cur_oh;
            red   = ~w_cur_oh;
         end
         ST_YELLOW: begin
            yellow = w_cur_oh;
            red    = ~w_cur_oh;
         end
`ifdef MAINT_FLASH_EN
         ST_FLASH: begin
            red = {NUM_PHASES{r_flash_on}};
         end
`endif
         default: ;
      endcase
   end

   assign cur_phase = r_cur;
   assign fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_traffic_controller_nphase.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : tb_traffic_controller_nphase
// Description : Directed self-checking bench for traffic_controller_nphase
//               (3 phases, short timing parameters).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_traffic_controller_nphase;

   logic       clk = 1'b0;
   logic       resetn;
   logic [2:0] req;
   logic [2:0] det;
   logic [2:0] green;
   logic [2:0] yellow;
   logic [2:0] red;
   logic [2:0] cur_phase;
   logic       fault;
`ifdef MAINT_FLASH_EN
   logic       flash_req;
`endif

   int tests     = 0;
   int fails     = 0;
   int fault_cnt = 0;
   int n;
   int ok;

   always #5 clk = ~clk;

   traffic_controller_nphase #(
      .NUM_PHASES      (3),
      .TW              (8),
      .GREEN_MIN       (4),
      .GREEN_MAX       (10),
      .GAP_TIME        (2),
      .YELLOW_TIME     (3),
      .ALLRED_TIME     (2),
      .SAFE_TIME_RESET (5),
      .SAFE_TIME       (4)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req       (req),
      .det       (det),
`ifdef MAINT_FLASH_EN
      .flash_req (flash_req),
`endif
      .green     (green),
      .yellow    (yellow),
      .red       (red),
      .cur_phase (cur_phase),
      .fault     (fault)
   );

   // Count every sampled cycle on which the fault pulse is high.
   always @(negedge clk) begin
      if (fault === 1'b1) begin
         fault_cnt <= fault_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // Counts consecutive negedge samples (starting with the current one) that
   // show the given lamp pattern. req is a one-cycle pulse; det drops at
   // sample index drop_at.
   task automatic run_count(input logic [2:0] g, input logic [2:0] y, input logic [2:0] r,
                            input int drop_at, output int cnt);
      cnt = 0;
      while ((green === g) && (yellow === y) && (red === r) && (cnt < 100)) begin
         if (cnt == 1) req = 3'b000;
         if (cnt == drop_at) det = 3'b000;
         cnt++;
         @(negedge clk);
      end
   endtask

   task automatic rest_check(input string tag, input logic [2:0] g, input int cycles);
      ok = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (green === g && red === ~g && yellow === 3'b000) ok++;
      end
      check(tag, ok, cycles);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0;
      req    = 3'b000;
      det    = 3'b000;
`ifdef MAINT_FLASH_EN
      flash_req = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_red",    red,       3'b111);
      check("rst_green",  green,     3'b000);
      check("rst_yellow", yellow,    3'b000);
      check("rst_fault",  fault,     1'b0);
      check("rst_cur",    cur_phase, 3'd2);

      // Reset release: SAFE 5 cycles, then rest in phase 0.
      resetn = 1'b1;
      run_count(3'b000, 3'b000, 3'b111, -1, n);
      check("safe_reset_len", n, 5);
      check("first_green", green, 3'b001);
      check("first_cur", cur_phase, 3'd0);
      rest_check("rest_green0", 3'b001, 20);

      // Demand only on phase 2: exit rest the cycle after latch, skip phase 1.
      req = 3'b100;
      run_count(3'b001, 3'b000, 3'b110, -1, n);
      check("rest_exit_len", n, 2);
      run_count(3'b000, 3'b001, 3'b110, -1, n);
      check("yellow0_len", n, 3);
      run_count(3'b000, 3'b000, 3'b111, -1, n);
      check("allred0_len", n, 2);
      check("skip_to_2_green", green, 3'b100);
      check("skip_to_2_cur", cur_phase, 3'd2);
      rest_check("rest_green2", 3'b100, 10);

      // Back to phase 0; demand[2] must have cleared, so phase 0 rests.
      req = 3'b001;
      run_count(3'b100, 3'b000, 3'b011, -1, n);
      check("rest2_exit_len", n, 2);
      run_count(3'b000, 3'b100, 3'b011, -1, n);
      check("yellow2_len", n, 3);
      run_count(3'b000, 3'b000, 3'b111, -1, n);
      check("allred2_len", n, 2);
      check("back_to_0_green", green, 3'b001);
      rest_check("dem2_cleared_rest", 3'b001, 15);

      // Asynchronous reset mid-cycle: lamps go red immediately.
      #2 resetn = 1'b0;
      #1;
      check("async_red",   red,   3'b111);
      check("async_green", green, 3'b000);
      @(negedge clk);
      resetn = 1'b1;
      run_count(3'b000, 3'b000, 3'b111, -1, n);
      check("safe_rerst_len", n, 5);

      // Minimum green: req[1] pulse at green cycle 1, det low.
      req = 3'b010;
      run_count(3'b001, 3'b000, 3'b110, -1, n);
      check("min_green_len", n, 4);
      run_count(3'b000, 3'b001, 3'b110, -1, n);
      check("yellow_len", n, 3);
      run_count(3'b000, 3'b000, 3'b111, -1, n);
      check("allred_len", n, 2);
      check("min_next_green", green, 3'b010);
      check("min_next_cur", cur_phase, 3'd1);

      // Detector held high: green runs to the maximum.
      det = 3'b010;
      req = 3'b100;
      run_count(3'b010, 3'b000, 3'b101, -1, n);
      check("max_green_len", n, 10);
      det = 3'b000;
      run_count(3'b000, 3'b010, 3'b101, -1, n);
      check("max_yellow_len", n, 3);
      run_count(3'b000, 3'b000, 3'b111, -1, n);
      check("max_allred_len", n, 2);
      check("max_next_cur", cur_phase, 3'd2);

      // Detector high for 5 cycles then low: gap expires at cycle 7.
      det = 3'b100;
      req = 3'b001;
      run_count(3'b100, 3'b000, 3'b011, 5, n);
      check("gap_green_len", n, 7);
      run_count(3'b000, 3'b100, 3'b011, -1, n);
      check("gap_yellow_len", n, 3);
      run_count(3'b000, 3'b000, 3'b111, -1, n);
      check("gap_allred_len", n, 2);
      check("gap_next_green", green, 3'b001);
      check("gap_next_cur", cur_phase, 3'd0);

      // Fault: unused encoding forced during green; demand[2] must survive.
      check("no_fault_yet", fault_cnt, 0);
      req = 3'b100;
      @(negedge clk);
      req = 3'b000;
      force dut.r_state = 3'b111;
      @(posedge clk);
      #1;
      force dut.r_state = 3'b000;
      release dut.r_state;
      @(negedge clk);
      check("fault_pulse", fault, 1'b1);
      check("fault_red", red, 3'b111);
      run_count(3'b000, 3'b000, 3'b111, -1, n);
      check("fault_safe_len", n, 4);
      check("fault_keeps_demand", green, 3'b100);
      check("fault_next_cur", cur_phase, 3'd2);
      check("fault_pulse_count", fault_cnt, 1);

`ifdef MAINT_FLASH_EN
      // Maintenance flash from green phase 2.
      flash_req = 1'b1;
      run_count(3'b100, 3'b000, 3'b011, -1, n);
      check("flash_green_len", n, 4);
      run_count(3'b000, 3'b100, 3'b011, -1, n);
      check("flash_yellow_len", n, 3);
      run_count(3'b000, 3'b000, 3'b111, -1, n);
      check("flash_allred_lit_len", n, 10);
      run_count(3'b000, 3'b000, 3'b000, -1, n);
      check("flash_dark_len", n, 8);
      flash_req = 1'b0;
      run_count(3'b000, 3'b000, 3'b111, -1, n);
      check("flash_lit_safe_len", n, 12);
      check("flash_exit_green", green, 3'b001);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
